// File: rtl/mmio_write_arbiter.sv
// mmio_write_arbiter
// Shares the single DMEM/peripheral write port between the CPU store path and
// the sprite DMA engine. Round-robin arbitration, one-hot write-enable decode
// of the granted address, saturating unmapped-write counter and a minimum
// spacing between consecutive VGA register writes.
module mmio_write_arbiter #(
  parameter int unsigned VGA_HOLD_CYCLES = 4,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_stall,
  input  logic                 dma_req,
  input  logic [31:0]          dma_addr,
  input  logic [31:0]          dma_wdata,
  output logic                 dma_gnt,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_wdata,
  output logic                 dmem_we,
  output logic                 vga_we,
  output logic                 seg_we,
  output logic                 timer_we,
  output logic                 err_unmapped,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Hold counter must be able to represent VGA_HOLD_CYCLES; keep it at least 1 bit wide.
  localparam int unsigned CNT_W = (VGA_HOLD_CYCLES < 1) ? 1 : $clog2(VGA_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(VGA_HOLD_CYCLES);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {
    TGT_DMEM,
    TGT_VGA,
    TGT_SEG,
    TGT_TIMER,
    TGT_NONE
  } target_e;

  // Only the low 12 address bits select the target; the upper bits are ignored.
  function automatic target_e decode(input logic [11:0] a);
    target_e t;
    if (!a[11]) begin
      t = TGT_DMEM;
    end else begin
      case (a)
        12'h800: t = TGT_VGA;
        12'h804: t = TGT_SEG;
        12'h814: t = TGT_TIMER;
        default: t = TGT_NONE;
      endcase
    end
    return t;
  endfunction

  // Registered state
  logic                 cpu_gnt_q,   cpu_gnt_d;
  logic                 dma_gnt_q,   dma_gnt_d;
  logic [31:0]          bus_addr_q,  bus_addr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic                 dmem_we_q,   dmem_we_d;
  logic                 vga_we_q,    vga_we_d;
  logic                 seg_we_q,    seg_we_d;
  logic                 timer_we_q,  timer_we_d;
  logic                 err_q,       err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [CNT_W-1:0]     vga_cnt_q,   vga_cnt_d;
  logic                 last_dma_q,  last_dma_d;

  // Arbitration helpers
  target_e cpu_tgt, dma_tgt, sel_tgt;
  logic    vga_busy, cpu_elig, dma_elig, pick_cpu, pick_dma, issue;

  // Decode both requests, qualify eligibility against the VGA hold, then pick a winner.
  always_comb begin
    cpu_tgt  = decode(cpu_addr[11:0]);
    dma_tgt  = decode(dma_addr[11:0]);
    vga_busy = (vga_cnt_q != '0);
    cpu_elig = cpu_req && !((cpu_tgt == TGT_VGA) && vga_busy);
    dma_elig = dma_req && !((dma_tgt == TGT_VGA) && vga_busy);
    // On a tie the master that did not win last time goes first.
    pick_cpu = cpu_elig && (!dma_elig || last_dma_q);
    pick_dma = dma_elig && !pick_cpu;
    issue    = pick_cpu || pick_dma;
    sel_tgt  = pick_cpu ? cpu_tgt : dma_tgt;
  end

  // Next-state for the issued write, enables, error tracking and VGA spacing.
  always_comb begin
    cpu_gnt_d   = pick_cpu;
    dma_gnt_d   = pick_dma;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    dmem_we_d   = issue && (sel_tgt == TGT_DMEM);
    vga_we_d    = issue && (sel_tgt == TGT_VGA);
    seg_we_d    = issue && (sel_tgt == TGT_SEG);
    timer_we_d  = issue && (sel_tgt == TGT_TIMER);
    err_d       = issue && (sel_tgt == TGT_NONE);
    err_cnt_d   = err_cnt_q;
    vga_cnt_d   = vga_cnt_q;
    last_dma_d  = last_dma_q;

    if (pick_cpu) begin
      bus_addr_d  = cpu_addr;
      bus_wdata_d = cpu_wdata;
      last_dma_d  = 1'b0;
    end else if (pick_dma) begin
      bus_addr_d  = dma_addr;
      bus_wdata_d = dma_wdata;
      last_dma_d  = 1'b1;
    end

    if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    // A VGA write restarts the spacing window; otherwise count down to zero.
    if (vga_we_d) begin
      vga_cnt_d = HOLD_LOAD;
    end else if (vga_busy) begin
      vga_cnt_d = vga_cnt_q - CNT_W'(1);
    end
  end

  // State register; last grant resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      dmem_we_q   <= 1'b0;
      vga_we_q    <= 1'b0;
      seg_we_q    <= 1'b0;
      timer_we_q  <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      vga_cnt_q   <= '0;
      last_dma_q  <= 1'b1;
    end else begin
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      dmem_we_q   <= dmem_we_d;
      vga_we_q    <= vga_we_d;
      seg_we_q    <= seg_we_d;
      timer_we_q  <= timer_we_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      vga_cnt_q   <= vga_cnt_d;
      last_dma_q  <= last_dma_d;
    end
  end

  assign cpu_gnt      = cpu_gnt_q;
  assign dma_gnt      = dma_gnt_q;
  assign cpu_stall    = cpu_req & ~cpu_gnt_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign dmem_we      = dmem_we_q;
  assign vga_we       = vga_we_q;
  assign seg_we       = seg_we_q;
  assign timer_we     = timer_we_q;
  assign err_unmapped = err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_mmio_write_arbiter.sv
// Directed testbench for mmio_write_arbiter: hand-computed expectations,
// immediate assertions at each comparison point.
module tb_mmio_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        dmem_we;
  logic        vga_we;
  logic        seg_we;
  logic        timer_we;
  logic        err_unmapped;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  mmio_write_arbiter #(
    .VGA_HOLD_CYCLES(4),
    .ERR_CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_stall   (cpu_stall),
    .dma_req     (dma_req),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .dmem_we     (dmem_we),
    .vga_we      (vga_we),
    .seg_we      (seg_we),
    .timer_we    (timer_we),
    .err_unmapped(err_unmapped),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the grant/enable vector of the current cycle in one go.
  task automatic chk_vec(input string tag, input logic cg, input logic dg, input logic dm,
                         input logic vg, input logic sg, input logic tm, input logic er);
    chk({tag, ".cpu_gnt"},  {31'd0, cpu_gnt},      {31'd0, cg});
    chk({tag, ".dma_gnt"},  {31'd0, dma_gnt},      {31'd0, dg});
    chk({tag, ".dmem_we"},  {31'd0, dmem_we},      {31'd0, dm});
    chk({tag, ".vga_we"},   {31'd0, vga_we},       {31'd0, vg});
    chk({tag, ".seg_we"},   {31'd0, seg_we},       {31'd0, sg});
    chk({tag, ".timer_we"}, {31'd0, timer_we},     {31'd0, tm});
    chk({tag, ".err"},      {31'd0, err_unmapped}, {31'd0, er});
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    dma_req = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    dma_req   = 1'b0;
    dma_addr  = 32'h0;
    dma_wdata = 32'h0;

    // Reset state
    step();
    step();
    chk_vec("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.bus_addr",  bus_addr,  32'h0);
    chk("reset.bus_wdata", bus_wdata, 32'h0);
    chk("reset.err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    $display("txn reset released");

    // Test 1: single CPU write to DMEM
    cpu_req = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
    step();
    chk_vec("t1", 1, 0, 1, 0, 0, 0, 0);
    chk("t1.bus_addr",  bus_addr,  32'h10);
    chk("t1.bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("t1.cpu_stall", {31'd0, cpu_stall}, 32'd0);
    $display("txn t1 cpu write addr=%08h data=%08h", bus_addr, bus_wdata);
    cpu_req = 1'b0;
    step();
    chk_vec("t1.idle", 0, 0, 0, 0, 0, 0, 0);
    chk("t1.hold_addr", bus_addr, 32'h10);

    // Timer decode with upper address bits set (ignored)
    dma_req = 1'b1; dma_addr = 32'hABCD_1814; dma_wdata = 32'h0000_0777;
    step();
    chk_vec("tmr", 0, 1, 0, 0, 0, 1, 0);
    chk("tmr.bus_addr", bus_addr, 32'hABCD_1814);
    $display("txn timer dma write addr=%08h data=%08h", bus_addr, bus_wdata);
    dma_req = 1'b0;
    step();

    // Test 2: both held continuously -> strict alternation, CPU first after reset
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0804; cpu_wdata = 32'h0000_0011;
    dma_req = 1'b1; dma_addr = 32'h0000_0000; dma_wdata = 32'h0000_0022;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) begin
        chk_vec("t2.cpu", 1, 0, 0, 0, 1, 0, 0);
        chk("t2.cpu.stall", {31'd0, cpu_stall}, 32'd0);
        chk("t2.cpu.wdata", bus_wdata, 32'h11);
      end else begin
        chk_vec("t2.dma", 0, 1, 1, 0, 0, 0, 0);
        chk("t2.dma.stall", {31'd0, cpu_stall}, 32'd1);
        chk("t2.dma.wdata", bus_wdata, 32'h22);
      end
      $display("txn t2 cycle %0d cpu_gnt=%0b dma_gnt=%0b addr=%08h", i, cpu_gnt, dma_gnt, bus_addr);
    end

    // Test 3: DMA streams VGA writes, CPU DMEM write slips in during the hold
    do_reset();
    dma_req = 1'b1; dma_addr = 32'h0000_0800; dma_wdata = 32'h0000_0055;
    step();
    chk_vec("t3.t0", 0, 1, 0, 1, 0, 0, 0);
    cpu_req = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h0000_0066;
    step();
    chk_vec("t3.t1", 1, 0, 1, 0, 0, 0, 0);
    chk("t3.t1.addr", bus_addr, 32'h20);
    cpu_req = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      step();
      chk("t3.vga_we", {31'd0, vga_we},  {31'd0, (c == 5 || c == 10)});
      chk("t3.dma_gnt", {31'd0, dma_gnt}, {31'd0, (c == 5 || c == 10)});
      $display("txn t3 t+%0d vga_we=%0b", c, vga_we);
    end
    dma_req = 1'b0;

    // Test 4: unmapped writes and counter saturation
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0808; cpu_wdata = 32'h0000_0099;
    step();
    chk_vec("t4.first", 1, 0, 0, 0, 0, 0, 1);
    chk("t4.cnt1", {24'd0, err_count}, 32'd1);
    for (int n = 2; n <= 300; n++) step();
    chk("t4.err_pulse", {31'd0, err_unmapped}, 32'd1);
    chk("t4.cnt_sat", {24'd0, err_count}, 32'd255);
    $display("txn t4 300 unmapped writes err_count=%0d", err_count);
    cpu_req = 1'b0;
    step();
    chk("t4.err_idle", {31'd0, err_unmapped}, 32'd0);
    chk("t4.cnt_hold", {24'd0, err_count}, 32'd255);

    // Test 5: both target VGA during hold
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0800; cpu_wdata = 32'h0000_00A0;
    step();
    chk_vec("t5.t0", 1, 0, 0, 1, 0, 0, 0);
    cpu_wdata = 32'h0000_00B0;
    dma_req = 1'b1; dma_addr = 32'h0000_0800; dma_wdata = 32'h0000_00C0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk_vec("t5.held", 0, 0, 0, 0, 0, 0, 0);
      chk("t5.stall", {31'd0, cpu_stall}, 32'd1);
    end
    step();
    chk_vec("t5.t5", 0, 1, 0, 1, 0, 0, 0);
    chk("t5.t5.wdata", bus_wdata, 32'hC0);
    $display("txn t5 t+5 dma vga write data=%08h", bus_wdata);
    dma_req = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      step();
      chk("t5.cpu_wait", {31'd0, cpu_gnt}, 32'd0);
    end
    step();
    chk_vec("t5.t10", 1, 0, 0, 1, 0, 0, 0);
    chk("t5.t10.wdata", bus_wdata, 32'hB0);
    $display("txn t5 t+10 cpu vga write data=%08h", bus_wdata);
    cpu_req = 1'b0;

    // Test 6: asynchronous reset mid-hold with a pending request
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0800; cpu_wdata = 32'h0000_00D0;
    step();
    chk_vec("t6.t0", 1, 0, 0, 1, 0, 0, 0);
    cpu_wdata = 32'h0000_00E0;
    step();
    chk("t6.held", {31'd0, cpu_gnt}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("t6.async", 0, 0, 0, 0, 0, 0, 0);
    chk("t6.async.addr",  bus_addr,  32'h0);
    chk("t6.async.wdata", bus_wdata, 32'h0);
    dma_req = 1'b1; dma_addr = 32'h0000_0800; dma_wdata = 32'h0000_00F0;
    step();
    rst_n = 1'b1;
    step();
    chk_vec("t6.after", 1, 0, 0, 1, 0, 0, 0);
    chk("t6.after.wdata", bus_wdata, 32'hE0);
    $display("txn t6 post-reset cpu vga write data=%08h", bus_wdata);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
